// File: rtl/sequence_capture_checker_if.sv
// Handshake bundle between the colour decoder/game controller and the sequence capture checker.
// The controller (master) drives the round and entry signals; the checker (slave) returns capture state and verdict.
interface sequence_capture_checker_if #(
   parameter int COLOUR_W = 2,
   parameter int MAX_LEN  = 16,
   parameter int LEN_W    = 5
);
   logic                         en;
   logic                         colour_in;
   logic [COLOUR_W-1:0]          colour_val;
   logic [LEN_W-1:0]             sequence_len;
   logic [COLOUR_W*MAX_LEN-1:0]  expected_seq;
   logic [COLOUR_W*MAX_LEN-1:0]  captured_seq;
   logic [LEN_W-1:0]             count;
   logic                         done;
   logic                         pass;
   logic                         fail;
   logic                         timeout;

   modport master (
      output en, colour_in, colour_val, sequence_len, expected_seq,
      input  captured_seq, count, done, pass, fail, timeout
   );

   modport slave (
      input  en, colour_in, colour_val, sequence_len, expected_seq,
      output captured_seq, count, done, pass, fail, timeout
   );
endinterface

// File: rtl/sequence_capture_checker.sv
// Collects one colour per strobe into a packed register and checks it live against the expected game sequence.
// A round ends on first mismatch, on an inactivity timeout, or once the latched length has been matched.
module sequence_capture_checker #(
   parameter int COLOUR_W       = 2,
   parameter int MAX_LEN        = 16,
   parameter int LEN_W          = 5,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   sequence_capture_checker_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                       state;
   logic [COLOUR_W*MAX_LEN-1:0]  captured;
   logic [LEN_W-1:0]             count;
   logic [LEN_W-1:0]             len;
   logic [TO_W-1:0]              timer;
   logic                         done;
   logic                         pass;
   logic                         fail;
   logic                         timeout;

   logic [COLOUR_W-1:0]          exp_sym;
   logic                         hit_last;
   logic                         timer_expired;

   // Requested lengths beyond the register capacity are clamped to MAX_LEN.
   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
      return (int'(l) > MAX_LEN) ? LEN_W'(MAX_LEN) : l;
   endfunction

   always_comb begin
      exp_sym       = bus.expected_seq[int'(count)*COLOUR_W +: COLOUR_W];
      hit_last      = ((count + LEN_W'(1)) == len);
      timer_expired = (TIMEOUT_CYCLES != 0) && (timer == TO_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         captured <= '0;
         count    <= '0;
         len      <= '0;
         timer    <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done    <= 1'b0;
               pass    <= 1'b0;
               fail    <= 1'b0;
               timeout <= 1'b0;
               if (bus.en) begin
                  state    <= WAIT;
                  len      <= sat_len(bus.sequence_len);
                  captured <= '0;
                  count    <= '0;
                  timer    <= '0;
               end
            end
            WAIT: begin
               if (!bus.en) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (len == '0) begin
                  state <= DONE;
                  pass  <= 1'b1;
                  done  <= 1'b1;
               end else if (bus.colour_in) begin
                  // The entry is stored and counted even when it is the one that fails the round.
                  captured[int'(count)*COLOUR_W +: COLOUR_W] <= bus.colour_val;
                  count <= count + LEN_W'(1);
                  timer <= '0;
                  if (bus.colour_val != exp_sym) begin
                     state <= DONE;
                     fail  <= 1'b1;
                     done  <= 1'b1;
                  end else if (hit_last) begin
                     state <= DONE;
                     pass  <= 1'b1;
                     done  <= 1'b1;
                  end
               end else if (timer_expired) begin
                  state   <= DONE;
                  fail    <= 1'b1;
                  timeout <= 1'b1;
                  done    <= 1'b1;
               end else if (TIMEOUT_CYCLES != 0) begin
                  timer <= timer + TO_W'(1);
               end
            end
            DONE: begin
               if (!bus.en) begin
                  state   <= IDLE;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  fail    <= 1'b0;
                  timeout <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.captured_seq = captured;
   assign bus.count        = count;
   assign bus.done         = done;
   assign bus.pass         = pass;
   assign bus.fail         = fail;
   assign bus.timeout      = timeout;

endmodule
